sram22_req_bridge: RTL

- Initiator-side controller for an SRAM22 single-port macro (64x32, one write-mask bit).
- Accepts read/write requests on a valid/ready stream and drives the macro's we/wmask/addr/din pins from registers.
- Captures dout for reads only and returns read data in order on a valid/ready response stream with credit-based backpressure.
- Sits between the core-side bus adapter and the macro; the only block that touches the SRAM pins.

---
 rtl/sram22_bridge_pkg.sv | 10 +
 rtl/sram22_rsp_fifo.sv | 34 +++
 rtl/sram22_req_bridge.sv | 104 ++++++++++
 3 files changed

// File: rtl/sram22_bridge_pkg.sv
// sram22_bridge_pkg: shared types and default sizes for the SRAM22 request bridge
package sram22_bridge_pkg;
  typedef enum logic {INIT, RUN} state_e;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 6;
  localparam int WMASK_W   = 1;
  localparam int RSP_D     = 4;
  localparam int RAM_DEPTH = 1 << ADDR_W;
  localparam int CREDIT_W  = $clog2(RSP_D + 1);
endpackage

// File: rtl/sram22_rsp_fifo.sv
// sram22_rsp_fifo: first-word-fall-through response FIFO with async active-high reset
module sram22_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [NW-1:0] cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign full_o  = cnt_q == NW'(DEPTH);
  assign empty_o = cnt_q == '0;
  always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + NW'(push_i) - NW'(pop_i);
    end
endmodule

// File: rtl/sram22_req_bridge.sv
// sram22_req_bridge: registered request-to-SRAM22 pin driver with credited in-order read responses
// Optional power-up zeroing sweep enabled by defining SRAM22_INIT_SWEEP_EN.
module sram22_req_bridge
  import sram22_bridge_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_W,
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int WMASK_WIDTH = WMASK_W,
  parameter int RSP_DEPTH   = RSP_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   busy,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  state_e state_q;
  logic [CW-1:0] credit_q, credit_d;
  logic s1_q, s2_q;
  logic sram_we_q;
  logic [WMASK_WIDTH-1:0] sram_wmask_q;
  logic [ADDR_WIDTH-1:0] sram_addr_q;
  logic [DATA_WIDTH-1:0] sram_din_q;
  logic acc, rd_acc, pop, empty, full;
`ifdef SRAM22_INIT_SWEEP_EN
  logic [ADDR_WIDTH-1:0] init_cnt_q;
`endif
  assign req_ready  = state_q == RUN && credit_q != '0;
  assign acc        = req_valid && req_ready;
  assign rd_acc     = acc && !req_we;
  assign rsp_valid  = !empty;
  assign pop        = rsp_valid && rsp_ready;
  assign busy       = state_q == INIT || credit_q != CW'(RSP_DEPTH);
  assign sram_we    = sram_we_q;
  assign sram_wmask = sram_wmask_q;
  assign sram_addr  = sram_addr_q;
  assign sram_din   = sram_din_q;
  always_comb credit_d = credit_q - CW'(rd_acc) + CW'(pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
`ifdef SRAM22_INIT_SWEEP_EN
      state_q    <= INIT;
      init_cnt_q <= '0;
`else
      state_q    <= RUN;
`endif
      credit_q     <= CW'(RSP_DEPTH);
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_wmask_q <= '0;
      sram_addr_q  <= '0;
      sram_din_q   <= '0;
    end else begin
      credit_q <= credit_d;
      s1_q     <= rd_acc;
      s2_q     <= s1_q;
`ifdef SRAM22_INIT_SWEEP_EN
      if (state_q == INIT) begin
        sram_we_q    <= 1'b1;
        sram_wmask_q <= '1;
        sram_addr_q  <= init_cnt_q;
        sram_din_q   <= '0;
        init_cnt_q   <= init_cnt_q + 1'b1;
        if (init_cnt_q == '1) state_q <= RUN;
      end else
`endif
      if (acc) begin
        sram_we_q    <= req_we;
        sram_wmask_q <= req_we ? req_wmask : '0;
        sram_addr_q  <= req_addr;
        sram_din_q   <= req_wdata;
      end else begin
        sram_we_q    <= 1'b0;
        sram_wmask_q <= '0;
      end
    end
  // s2_q alone gates capture, so write-cycle X on dout never reaches the FIFO
  sram22_rsp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s2_q),
    .din_i   (sram_dout),
    .pop_i   (pop),
    .dout_o  (rsp_rdata),
    .full_o  (full),
    .empty_o (empty)
  );
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(s2_q && full && !pop));
  a_credit_max:  assert property (@(posedge clk) disable iff (rst) credit_q <= CW'(RSP_DEPTH));
endmodule
